arm_shift_stage: RTL and testbench
==================================

// Module: arm_shift_stage
// PURPOSE
//  Operand-2 shifter/pipeline stage directly upstream of the ALU.
//  Takes decoded data-processing fields, applies ARM shift/rotate to form alu_op2
//  plus shifter carry-out, and registers op1/op2/op_sel for the ALU.
//  Valid/ready handshake on both sides; 1-cycle latency; absorbs ALU-side stalls.
// PARAMETERS
//  (none; datapath fixed at 32 bits, op_sel at 4 bits)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  flush          in   1   sync flush: drop all held/in-flight items
//  in_valid       in   1   upstream item valid
//  in_ready       out  1   stage can accept
//  in_alu_op_sel  in   4   ALU opcode, passed through
//  in_rn          in   32  operand 1, passed through
//  in_imm         in   1   1: rotated-immediate form; 0: shifted-register form
//  in_imm8        in   8   immediate byte
//  in_rot         in   4   immediate rotate field (ROR by 2*in_rot)
//  in_rm          in   32  register operand to shift
//  in_shift_type  in   2   0 LSL, 1 LSR, 2 ASR, 3 ROR
//  in_shift_reg   in   1   1: amount = in_rs[7:0]; 0: amount = in_shift_imm
//  in_shift_imm   in   5   immediate shift amount
//  in_rs          in   8   register shift amount (Rs[7:0])
//  in_c_flag      in   1   current CPSR C
//  out_valid      out  1   ALU-side item valid
//  out_ready      in   1   ALU side accepts
//  out_alu_op_sel out  4   to alu_op_sel
//  out_op1        out  32  to alu_op1
//  out_op2        out  32  to alu_op2
//  out_shift_c    out  1   shifter carry-out (C for logical ops)
// BEHAVIOUR
//  Reset: out_valid=0, all out_* data=0, skid empty; in_ready per mode below.
//  Transfer on valid&ready per side; output regs load on input transfer; latency 1.
//  out_* data stable while out_valid & ~out_ready.
//  Immediate form: op2 = imm8 ROR (2*rot); c = (rot==0) ? in_c_flag : op2[31].
//  Imm amount (n=in_shift_imm):
//   LSL #0 -> rm, c=in_c_flag; LSL n -> rm<<n, c=rm[32-n]
//   LSR #0 == LSR #32 -> 0, c=rm[31]; ASR #0 == ASR #32 -> {32{rm[31]}}, c=rm[31]
//   ROR #0 == RRX -> {in_c_flag, rm[31:1]}, c=rm[0]; else rm ROR n, c=rm[n-1]
//  Reg amount (a=in_rs):
//   a==0 -> rm, c=in_c_flag (all types)
//   LSL: a<32 normal; a==32 -> 0,c=rm[0]; a>32 -> 0,c=0
//   LSR: a<32 normal; a==32 -> 0,c=rm[31]; a>32 -> 0,c=0
//   ASR: a>=32 -> {32{rm[31]}}, c=rm[31]
//   ROR: a[4:0]==0 -> rm, c=rm[31]; else rotate by a[4:0], c=rm[a[4:0]-1]
//  flush: next edge out_valid=0, skid cleared; same-cycle input discarded.
//  flush has priority over in/out transfers.
//  Reset mid-transfer: item lost, outputs return to reset values immediately.
// CONFIGURATION
//  ARM_SHIFT_SKID_EN undefined: in_ready = ~out_valid | out_ready (combinational).
//  ARM_SHIFT_SKID_EN defined: in_ready is a flop (=skid empty); one-entry skid buffer
//   captures an accepted item when output stalls; drains to output before new input;
//   order preserved; reset in_ready=1; zero bubbles at full throughput.
// TESTING
//  imm8=0xFF, rot=4, c_in=0 -> next cycle out_op2=0xFF000000, out_shift_c=1
//  reg LSL, rm=0x00000001, rs=32 -> op2=0, c=1; rs=33 -> op2=0, c=0
//  imm LSR #0, rm=0x80000000 -> op2=0, c=1; imm ROR #0, rm=1, c_in=1 -> 0x80000000, c=1
//  reg ROR, rm=0x12345678, rs=0x20 -> op2=0x12345678, c=0; rs=0 -> c=c_in
//  back-to-back 4 items, out_ready=0 3 cycles -> no loss/dup, order kept; skid build: in_ready=0 while full
//  flush with out_valid=1 and skid full -> out_valid=0 next cycle; rst_n low mid-stall -> all outputs reset

Source files
------------

// File: rtl/arm_shift_stage.sv
// arm_shift_stage: ARM operand-2 shifter with a registered valid/ready stage feeding the ALU.
// Define ARM_SHIFT_SKID_EN to get a registered in_ready backed by a one-entry skid buffer.
module arm_shift_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_alu_op_sel,
  input  logic [31:0] in_rn,
  input  logic        in_imm,
  input  logic [7:0]  in_imm8,
  input  logic [3:0]  in_rot,
  input  logic [31:0] in_rm,
  input  logic [1:0]  in_shift_type,
  input  logic        in_shift_reg,
  input  logic [4:0]  in_shift_imm,
  input  logic [7:0]  in_rs,
  input  logic        in_c_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op_sel,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic        out_shift_c
);
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction
  logic [7:0]  amt;
  logic [4:0]  lo, lsl_i, r_i;
  logic [31:0] sh_op2;
  logic        sh_c;
  always_comb begin
    amt = in_shift_reg ? in_rs : {3'd0, in_shift_imm};
    if (!in_shift_reg && in_shift_imm == 5'd0 && (in_shift_type == 2'd1 || in_shift_type == 2'd2))
      amt = 8'd32;
    lo = amt[4:0];
    lsl_i = 5'd0 - lo;
    r_i = lo - 5'd1;
    sh_op2 = in_rm;
    sh_c = in_c_flag;
    if (in_imm) begin
      sh_op2 = ror32({24'd0, in_imm8}, {in_rot, 1'b0});
      sh_c = (in_rot == 4'd0) ? in_c_flag : sh_op2[31];
    end else if (!in_shift_reg && in_shift_type == 2'd3 && in_shift_imm == 5'd0) begin
      sh_op2 = {in_c_flag, in_rm[31:1]};
      sh_c = in_rm[0];
    end else if (amt != 8'd0) begin
      case (in_shift_type)
        2'd0: begin
          sh_op2 = (amt < 8'd32) ? in_rm << lo : 32'd0;
          sh_c = (amt < 8'd32) ? in_rm[lsl_i] : (amt == 8'd32) & in_rm[0];
        end
        2'd1: begin
          sh_op2 = (amt < 8'd32) ? in_rm >> lo : 32'd0;
          sh_c = (amt < 8'd32) ? in_rm[r_i] : (amt == 8'd32) & in_rm[31];
        end
        2'd2: begin
          sh_op2 = (amt < 8'd32) ? 32'($signed(in_rm) >>> lo) : {32{in_rm[31]}};
          sh_c = (amt < 8'd32) ? in_rm[r_i] : in_rm[31];
        end
        default: begin
          sh_op2 = ror32(in_rm, lo);
          sh_c = (lo == 5'd0) ? in_rm[31] : in_rm[r_i];
        end
      endcase
    end
  end
  logic        out_valid_q, out_valid_d, c_q, c_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic        in_xfer, load_in;
`ifdef ARM_SHIFT_SKID_EN
  logic        skid_valid_q, skid_valid_d, in_ready_q, in_ready_d, skid_c_q, skid_c_d;
  logic        free, from_skid, to_skid;
  logic [3:0]  skid_sel_q, skid_sel_d;
  logic [31:0] skid_op1_q, skid_op1_d, skid_op2_q, skid_op2_d;
  assign in_ready = in_ready_q;
  // The skid entry always drains into the output before new input, keeping order.
  always_comb begin
    in_xfer = in_valid & in_ready_q;
    free = ~out_valid_q | out_ready;
    from_skid = free & skid_valid_q;
    load_in = in_xfer & free;
    to_skid = in_xfer & ~free;
    out_valid_d = ~flush & (~free | skid_valid_q | in_xfer);
    skid_valid_d = ~flush & (to_skid | (skid_valid_q & ~free));
    in_ready_d = ~skid_valid_d;
    sel_d = from_skid ? skid_sel_q : load_in ? in_alu_op_sel : sel_q;
    op1_d = from_skid ? skid_op1_q : load_in ? in_rn : op1_q;
    op2_d = from_skid ? skid_op2_q : load_in ? sh_op2 : op2_q;
    c_d = from_skid ? skid_c_q : load_in ? sh_c : c_q;
    skid_sel_d = to_skid ? in_alu_op_sel : skid_sel_q;
    skid_op1_d = to_skid ? in_rn : skid_op1_q;
    skid_op2_d = to_skid ? sh_op2 : skid_op2_q;
    skid_c_d = to_skid ? sh_c : skid_c_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      skid_sel_q <= 4'd0;
      skid_op1_q <= 32'd0;
      skid_op2_q <= 32'd0;
      skid_c_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      in_ready_q <= in_ready_d;
      skid_sel_q <= skid_sel_d;
      skid_op1_q <= skid_op1_d;
      skid_op2_q <= skid_op2_d;
      skid_c_q <= skid_c_d;
    end
`else
  assign in_ready = ~out_valid_q | out_ready;
  always_comb begin
    in_xfer = in_valid & in_ready;
    load_in = in_xfer;
    out_valid_d = ~flush & (in_xfer | (out_valid_q & ~out_ready));
    sel_d = load_in ? in_alu_op_sel : sel_q;
    op1_d = load_in ? in_rn : op1_q;
    op2_d = load_in ? sh_op2 : op2_q;
    c_d = load_in ? sh_c : c_q;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sel_q <= 4'd0;
      op1_q <= 32'd0;
      op2_q <= 32'd0;
      c_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_q <= sel_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      c_q <= c_d;
    end
  assign out_valid = out_valid_q;
  assign out_alu_op_sel = sel_q;
  assign out_op1 = op1_q;
  assign out_op2 = op2_q;
  assign out_shift_c = c_q;
endmodule

// File: tb/tb_arm_shift_stage.sv
// tb_arm_shift_stage: randomized scoreboard bench for arm_shift_stage, with a bit-serial shifter reference.
// Honours ARM_SHIFT_SKID_EN the same way as the design.
module tb_arm_shift_stage;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_shift_c;
  logic [3:0]  in_alu_op_sel = 0, in_rot = 0, out_alu_op_sel;
  logic [31:0] in_rn = 0, in_rm = 0, out_op1, out_op2;
  logic        in_imm = 0, in_shift_reg = 0, in_c_flag = 0;
  logic [7:0]  in_imm8 = 0, in_rs = 0;
  logic [1:0]  in_shift_type = 0;
  logic [4:0]  in_shift_imm = 0;
  int errors = 0, checks = 0, popped = 0;
  typedef struct packed { logic [3:0] sel; logic [31:0] op1; logic [31:0] op2; logic c; } item_t;
  item_t q[$];
  arm_shift_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op_sel(in_alu_op_sel), .in_rn(in_rn), .in_imm(in_imm), .in_imm8(in_imm8),
    .in_rot(in_rot), .in_rm(in_rm), .in_shift_type(in_shift_type), .in_shift_reg(in_shift_reg),
    .in_shift_imm(in_shift_imm), .in_rs(in_rs), .in_c_flag(in_c_flag), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_op_sel(out_alu_op_sel), .out_op1(out_op1), .out_op2(out_op2),
    .out_shift_c(out_shift_c)
  );
  always #5 clk = ~clk;
  // Reference: shift one bit at a time, the carry being the last bit shifted out.
  function automatic item_t model();
    item_t it;
    logic [31:0] x;
    logic c;
    int n;
    x = in_rm;
    c = in_c_flag;
    if (in_imm) begin
      x = {24'd0, in_imm8};
      for (int i = 0; i < 2 * in_rot; i++) x = {x[0], x[31:1]};
      c = (in_rot == 0) ? in_c_flag : x[31];
    end else if (!in_shift_reg && in_shift_type == 3 && in_shift_imm == 0) begin
      c = x[0];
      x = {in_c_flag, x[31:1]};
    end else begin
      n = in_shift_reg ? int'(in_rs) : int'(in_shift_imm);
      if (!in_shift_reg && n == 0 && (in_shift_type == 1 || in_shift_type == 2)) n = 32;
      for (int i = 0; i < n; i++) begin
        if (in_shift_type == 0) begin c = x[31]; x = x << 1; end
        else if (in_shift_type == 1) begin c = x[0]; x = x >> 1; end
        else if (in_shift_type == 2) begin c = x[0]; x = {x[31], x[31:1]}; end
        else begin c = x[0]; x = {x[0], x[31:1]}; end
      end
    end
    it.sel = in_alu_op_sel;
    it.op1 = in_rn;
    it.op2 = x;
    it.c = c;
    return it;
  endfunction
  task automatic randomize_fields();
    in_alu_op_sel = 4'($urandom);
    in_rn = $urandom;
    in_rm = $urandom;
    in_imm = ($urandom_range(0, 3) == 0);
    in_imm8 = 8'($urandom);
    in_rot = 4'($urandom);
    in_shift_type = 2'($urandom);
    in_shift_reg = $urandom_range(0, 1) == 1;
    in_shift_imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 3))
      0: in_rs = 8'($urandom_range(0, 40));
      1: in_rs = 8'(32 * $urandom_range(0, 7));
      2: in_rs = 8'd255;
      default: in_rs = 8'($urandom);
    endcase
    in_c_flag = $urandom_range(0, 1) == 1;
  endtask
  task automatic cycle(output bit acc);
    logic exp_ir;
    item_t it;
    acc = 0;
    @(negedge clk);
`ifdef ARM_SHIFT_SKID_EN
    exp_ir = q.size() < 2;
`else
    exp_ir = q.size() == 0 || out_ready;
`endif
    checks++;
    if (in_ready !== exp_ir) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b (held %0d)", in_ready, exp_ir, q.size());
    end
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if ({out_alu_op_sel, out_op1, out_op2, out_shift_c} !== q[0]) begin
        errors++;
        $display("FAIL out_data: got sel=%h op1=%h op2=%h c=%b expected sel=%h op1=%h op2=%h c=%b",
                 out_alu_op_sel, out_op1, out_op2, out_shift_c, q[0].sel, q[0].op1, q[0].op2, q[0].c);
      end
    end
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) begin
        it = model();
        q.push_back(it);
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    out_ready = 0;
    #12;
    checks++;
    if (out_valid !== 0 || out_op1 !== 0 || out_op2 !== 0 || out_alu_op_sel !== 0 || out_shift_c !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset: got v=%b op1=%h op2=%h sel=%h c=%b ir=%b expected all 0 and in_ready 1",
               out_valid, out_op1, out_op2, out_alu_op_sel, out_shift_c, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic directed(input string name, input logic imm, input logic [7:0] imm8, input logic [3:0] rot,
                          input logic [31:0] rm, input logic [1:0] st, input logic sreg, input logic [4:0] simm,
                          input logic [7:0] rs, input logic cf, input logic [31:0] exp_op2, input logic exp_c);
    logic [31:0] rn;
    logic [3:0] sel;
    rn = $urandom;
    sel = 4'($urandom);
    in_rn = rn; in_alu_op_sel = sel; in_imm = imm; in_imm8 = imm8; in_rot = rot; in_rm = rm;
    in_shift_type = st; in_shift_reg = sreg; in_shift_imm = simm; in_rs = rs; in_c_flag = cf;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_op2 !== exp_op2 || out_shift_c !== exp_c || out_op1 !== rn || out_alu_op_sel !== sel) begin
      errors++;
      $display("FAIL %s: got v=%b op2=%h c=%b op1=%h sel=%h expected v=1 op2=%h c=%b op1=%h sel=%h",
               name, out_valid, out_op2, out_shift_c, out_op1, out_alu_op_sel, exp_op2, exp_c, rn, sel);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_shifts();
    directed("imm_rot4", 1, 8'hFF, 4'd4, 0, 0, 0, 0, 0, 0, 32'hFF000000, 1);
    directed("lsl_reg32", 0, 0, 0, 32'h1, 0, 1, 0, 8'd32, 0, 32'h0, 1);
    directed("lsl_reg33", 0, 0, 0, 32'h1, 0, 1, 0, 8'd33, 1, 32'h0, 0);
    directed("lsr_imm0", 0, 0, 0, 32'h80000000, 1, 0, 0, 0, 0, 32'h0, 1);
    directed("rrx", 0, 0, 0, 32'h1, 3, 0, 0, 0, 1, 32'h80000000, 1);
    directed("ror_reg32", 0, 0, 0, 32'h12345678, 3, 1, 0, 8'h20, 1, 32'h12345678, 0);
    directed("ror_reg0", 0, 0, 0, 32'h12345678, 3, 1, 0, 8'h00, 1, 32'h12345678, 1);
    directed("asr_imm0", 0, 0, 0, 32'h80000001, 2, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    directed("lsl_imm4", 0, 0, 0, 32'hF000000F, 0, 0, 5'd4, 0, 0, 32'h000000F0, 1);
    directed("lsr_reg4", 0, 0, 0, 32'h00000018, 1, 1, 0, 8'd4, 0, 32'h00000001, 1);
  endtask
  task automatic test_random();
    bit acc;
    randomize_fields();
    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 39) == 0;
      cycle(acc);
      if (acc) randomize_fields();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle(acc);
  endtask
  task automatic test_back_to_back();
    bit acc;
    int k, start;
    k = 0;
    start = popped;
    randomize_fields();
    for (int t = 0; t < 30; t++) begin
      in_valid = k < 4;
      out_ready = t >= 3;
      cycle(acc);
      if (acc) begin k++; randomize_fields(); end
    end
    in_valid = 0;
    checks++;
    if (k != 4 || popped - start != 4) begin
      errors++;
      $display("FAIL back_to_back: accepted %0d delivered %0d expected 4 and 4", k, popped - start);
    end
  endtask
  task automatic test_flush();
    bit acc;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin cycle(acc); randomize_fields(); end
    flush = 1;
    cycle(acc);
    flush = 0;
    in_valid = 0;
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL flush: got out_valid=%b in_ready=%b expected 0 and 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) cycle(acc);
    out_ready = 1;
    cycle(acc);
  endtask
  task automatic test_reset_mid();
    bit acc;
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin cycle(acc); randomize_fields(); end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || out_op1 !== 0 || out_op2 !== 0 || out_alu_op_sel !== 0 || out_shift_c !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b op1=%h op2=%h sel=%h c=%b ir=%b expected all 0 and in_ready 1",
               out_valid, out_op1, out_op2, out_alu_op_sel, out_shift_c, in_ready);
    end
    q.delete();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int i = 0; i < 2; i++) cycle(acc);
  endtask
  initial begin
    test_reset();
    test_shifts();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
